// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Iterative MULT/MULTU/DIV/DIVU unit for the EX stage. One shift-add
//   (multiply) or shift-subtract (divide) step per cycle, REG_SIZE steps per
//   operation. The single 32-bit add/subtract of each step is done by the
//   shared EX-stage ALU, which this block borrows while iterating; shifts,
//   carry/borrow and the final sign fix-up are done locally. Owns HI/LO.
//
// Handshake: i_start is honoured only in IDLE. o_stall rises combinationally
//   with that i_start and stays high until the cycle in which o_done pulses;
//   o_done is a one-cycle pulse and HI/LO are valid from that cycle on.
//   i_start outside IDLE is ignored.
//
// Ports
//   i_clk, i_reset       clock (rising edge), asynchronous active-low reset
//   i_start, i_op        start pulse; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   i_A, i_B             multiplicand/dividend, multiplier/divisor
//   i_alu_result         shared ALU result for o_alu_A/o_alu_B/o_alu_ctrl
//   o_alu_sel            1 while the sequencer owns the ALU operands
//   o_alu_A, o_alu_B     ALU operands (0 when not owned)
//   o_alu_ctrl           4'h3 ADD, 4'h4 SUB (0 when not owned)
//   o_stall              freeze IF/ID/EX
//   o_done               one-cycle completion pulse
//   o_div0               sticky divide-by-zero flag, cleared on next start
//   o_hi, o_lo           HI/LO registers
//   o_state              current FSM state, for debug visibility
module muldiv_sequencer #(
    parameter int REG_SIZE      = 32,
    parameter int ALU_CTRL_SIZE = 4
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_start,
    input  logic [1:0]               i_op,
    input  logic [REG_SIZE-1:0]      i_A,
    input  logic [REG_SIZE-1:0]      i_B,
    input  logic [REG_SIZE-1:0]      i_alu_result,
    output logic                     o_alu_sel,
    output logic [REG_SIZE-1:0]      o_alu_A,
    output logic [REG_SIZE-1:0]      o_alu_B,
    output logic [ALU_CTRL_SIZE-1:0] o_alu_ctrl,
    output logic                     o_stall,
    output logic                     o_done,
    output logic                     o_div0,
    output logic [REG_SIZE-1:0]      o_hi,
    output logic [REG_SIZE-1:0]      o_lo,
    output logic [1:0]               o_state
);

    localparam int CW = $clog2(REG_SIZE);
    localparam logic [CW-1:0] LAST = CW'(REG_SIZE - 1);
    localparam logic [ALU_CTRL_SIZE-1:0] ALU_ADD = ALU_CTRL_SIZE'(3);
    localparam logic [ALU_CTRL_SIZE-1:0] ALU_SUB = ALU_CTRL_SIZE'(4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  is_div_q, is_div_d;   // op class of the latched op
    logic                  sa_q, sa_d, sb_q, sb_d; // operand signs (0 for unsigned ops)
    logic                  dz_q, dz_d;           // pending divide-by-zero
    logic [REG_SIZE-1:0]   wh_q, wh_d;           // multiply: hi  / divide: R
    logic [REG_SIZE-1:0]   wl_q, wl_d;           // multiply: lo  / divide: Q
    logic [REG_SIZE-1:0]   m_q, m_d;             // multiply: M   / divide: D
    logic [REG_SIZE-1:0]   alat_q, alat_d;       // raw i_A, reported as HI on divide-by-zero
    logic [REG_SIZE-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic                  done_q, done_d;
    logic                  div0_q, div0_d;

    // Divide step: remainder shifted left with the next dividend bit.
    logic [REG_SIZE-1:0]   rs;
    assign rs = {wh_q[REG_SIZE-2:0], wl_q[REG_SIZE-1]};

    // ALU operand drive depends on registered state only, so the external
    // ALU result never feeds back into these outputs.
    always_comb begin
        o_alu_sel  = 1'b0;
        o_alu_A    = '0;
        o_alu_B    = '0;
        o_alu_ctrl = '0;
        if (state_q == ITER) begin
            o_alu_sel = 1'b1;
            if (!is_div_q) begin
                o_alu_A    = wh_q;
                o_alu_B    = m_q;
                o_alu_ctrl = ALU_ADD;
            end else begin
                o_alu_A    = rs;
                o_alu_B    = m_q;
                o_alu_ctrl = ALU_SUB;
            end
        end
    end

    always_comb begin
        logic                  sgn;
        logic [REG_SIZE-1:0]   mag_a, mag_b;
        logic                  carry, ge;
        logic [2*REG_SIZE-1:0] prod;
        logic [REG_SIZE-1:0]   q_fix, r_fix;

        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        sa_d     = sa_q;
        sb_d     = sb_q;
        dz_d     = dz_q;
        wh_d     = wh_q;
        wl_d     = wl_q;
        m_d      = m_q;
        alat_d   = alat_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        div0_d   = div0_q;
        sgn      = 1'b0;
        mag_a    = '0;
        mag_b    = '0;
        carry    = 1'b0;
        ge       = 1'b0;
        prod     = '0;
        q_fix    = '0;
        r_fix    = '0;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    sgn      = ~i_op[0];
                    sa_d     = sgn & i_A[REG_SIZE-1];
                    sb_d     = sgn & i_B[REG_SIZE-1];
                    // -2^31 maps to 2^31, which is fine as an unsigned magnitude.
                    mag_a    = sa_d ? (~i_A + 1'b1) : i_A;
                    mag_b    = sb_d ? (~i_B + 1'b1) : i_B;
                    is_div_d = i_op[1];
                    wh_d     = '0;
                    wl_d     = i_op[1] ? mag_a : mag_b;
                    m_d      = i_op[1] ? mag_b : mag_a;
                    alat_d   = i_A;
                    cnt_d    = '0;
                    div0_d   = 1'b0;
                    dz_d     = i_op[1] && (i_B == '0);
                    state_d  = dz_d ? FIX : ITER;
                end
            end
            ITER: begin
                if (!is_div_q) begin
                    if (wl_q[0]) begin
                        carry = (i_alu_result < wh_q);
                        wh_d  = {carry, i_alu_result[REG_SIZE-1:1]};
                        wl_d  = {i_alu_result[0], wl_q[REG_SIZE-1:1]};
                    end else begin
                        wh_d  = {1'b0, wh_q[REG_SIZE-1:1]};
                        wl_d  = {wh_q[0], wl_q[REG_SIZE-1:1]};
                    end
                end else begin
                    // A set msb means the shifted remainder exceeds 32 bits,
                    // so it is certainly >= D.
                    ge   = wh_q[REG_SIZE-1] | (rs >= m_q);
                    wh_d = ge ? i_alu_result : rs;
                    wl_d = {wl_q[REG_SIZE-2:0], ge};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (dz_q) begin
                    hi_d   = alat_q;
                    lo_d   = '1;
                    div0_d = 1'b1;
                end else if (!is_div_q) begin
                    prod = {wh_q, wl_q};
                    if (sa_q ^ sb_q) begin
                        prod = ~prod + 1'b1;
                    end
                    hi_d = prod[2*REG_SIZE-1:REG_SIZE];
                    lo_d = prod[REG_SIZE-1:0];
                end else begin
                    q_fix = (sa_q ^ sb_q) ? (~wl_q + 1'b1) : wl_q;
                    r_fix = sa_q ? (~wh_q + 1'b1) : wh_q;
                    hi_d  = r_fix;
                    lo_d  = q_fix;
                end
                dz_d    = 1'b0;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            sa_q     <= 1'b0;
            sb_q     <= 1'b0;
            dz_q     <= 1'b0;
            wh_q     <= '0;
            wl_q     <= '0;
            m_q      <= '0;
            alat_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            sa_q     <= sa_d;
            sb_q     <= sb_d;
            dz_q     <= dz_d;
            wh_q     <= wh_d;
            wl_q     <= wl_d;
            m_q      <= m_d;
            alat_q   <= alat_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            div0_q   <= div0_d;
        end
    end

    assign o_stall = (state_q != IDLE) || i_start;
    assign o_done  = done_q;
    assign o_div0  = div0_q;
    assign o_hi    = hi_q;
    assign o_lo    = lo_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed cases followed by random operations,
// checked against an arithmetic reference model (64-bit multiply, truncating
// divide) and a queue of expected {HI, LO} results.
module tb_muldiv_sequencer;

    logic        i_clk;
    logic        i_reset;
    logic        i_start;
    logic [1:0]  i_op;
    logic [31:0] i_A, i_B;
    logic [31:0] i_alu_result;
    logic        o_alu_sel;
    logic [31:0] o_alu_A, o_alu_B;
    logic [3:0]  o_alu_ctrl;
    logic        o_stall, o_done, o_div0;
    logic [31:0] o_hi, o_lo;
    logic [1:0]  o_state;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];
    logic [31:0] prev_hi = 32'h0;
    logic [31:0] prev_lo = 32'h0;

    muldiv_sequencer #(.REG_SIZE(32), .ALU_CTRL_SIZE(4)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_op         (i_op),
        .i_A          (i_A),
        .i_B          (i_B),
        .i_alu_result (i_alu_result),
        .o_alu_sel    (o_alu_sel),
        .o_alu_A      (o_alu_A),
        .o_alu_B      (o_alu_B),
        .o_alu_ctrl   (o_alu_ctrl),
        .o_stall      (o_stall),
        .o_done       (o_done),
        .o_div0       (o_div0),
        .o_hi         (o_hi),
        .o_lo         (o_lo),
        .o_state      (o_state)
    );

    // Shared EX-stage ALU as seen by the sequencer.
    assign i_alu_result = (o_alu_ctrl == 4'h3) ? (o_alu_A + o_alu_B) :
                          (o_alu_ctrl == 4'h4) ? (o_alu_A - o_alu_B) : 32'h0;

    // clock / reset
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic; SV division truncates toward
    // zero and the remainder takes the dividend's sign, as MIPS requires.
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el, output logic ed);
        longint      as, bs, sq, sr;
        logic [63:0] ua, ub, up;
        as = longint'($signed(a));
        bs = longint'($signed(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        ed = 1'b0;
        case (op)
            2'b00: begin sq = as * bs; up = 64'(sq); eh = up[63:32]; el = up[31:0]; end
            2'b01: begin up = ua * ub; eh = up[63:32]; el = up[31:0]; end
            default: begin
                if (b == 32'h0) begin
                    ed = 1'b1; eh = a; el = 32'hFFFF_FFFF;
                end else if (op == 2'b10) begin
                    sq = as / bs; sr = as % bs;
                    up = 64'(sq); el = up[31:0];
                    up = 64'(sr); eh = up[31:0];
                end else begin
                    up = ua / ub; el = up[31:0];
                    up = ua % ub; eh = up[31:0];
                end
            end
        endcase
    endfunction

    // Driver: one operation, with an optional ignored second start at
    // iteration inject_at and an optional reset at iteration abort_at.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int inject_at, input int abort_at);
        logic [31:0] eh, el;
        logic        ed, seen;
        logic [63:0] exp_v;
        logic [3:0]  ectrl;
        int j, sel_cnt, ctrl_bad, idle_bad, stall_bad, exp_lat, late_done;
        model(op, a, b, eh, el, ed);
        exp_q.push_back({eh, el});
        ectrl   = op[1] ? 4'h4 : 4'h3;
        exp_lat = ed ? 1 : 33;
        sel_cnt = 0; ctrl_bad = 0; idle_bad = 0; stall_bad = 0;
        @(negedge i_clk);
        i_start = 1'b1; i_op = op; i_A = a; i_B = b;
        #1 check("stall_with_start", 64'(o_stall), 64'(1));
        @(posedge i_clk);
        j = -1; seen = 1'b0;
        while (!seen && j < 60) begin
            @(negedge i_clk);
            j++;
            i_start = 1'b0;
            i_A = $urandom; i_B = $urandom;
            if (j == inject_at) begin
                i_start = 1'b1;
                i_op = 2'($urandom_range(0, 3));
            end
            if (j == 0) check("div0_cleared_on_start", 64'(o_div0), 64'(0));
            if (j == 5) begin
                check("hi_hold", 64'(o_hi), 64'(prev_hi));
                check("lo_hold", 64'(o_lo), 64'(prev_lo));
            end
            if (j == abort_at) begin
                i_reset = 1'b0;
                #1;
                check("abort_hi", 64'(o_hi), 64'(0));
                check("abort_lo", 64'(o_lo), 64'(0));
                check("abort_stall", 64'(o_stall), 64'(0));
                check("abort_alu_sel", 64'(o_alu_sel), 64'(0));
                check("abort_done", 64'(o_done), 64'(0));
                @(negedge i_clk);
                i_reset = 1'b1;
                late_done = 0;
                repeat (40) begin
                    @(negedge i_clk);
                    if (o_done) late_done++;
                end
                check("abort_no_done", 64'(late_done), 64'(0));
                check("abort_idle_stall", 64'(o_stall), 64'(0));
                void'(exp_q.pop_front());
                prev_hi = 32'h0; prev_lo = 32'h0;
                return;
            end
            if (o_alu_sel) begin
                sel_cnt++;
                if (o_alu_ctrl !== ectrl) ctrl_bad++;
            end else if (o_alu_A !== 32'h0 || o_alu_B !== 32'h0 || o_alu_ctrl !== 4'h0) begin
                idle_bad++;
            end
            if (!o_done && o_stall !== 1'b1) stall_bad++;
            if (o_done) seen = 1'b1;
        end
        check("done_seen", 64'(seen), 64'(1));
        check("latency", 64'(j), 64'(exp_lat));
        exp_v = exp_q.pop_front();
        check("hi", 64'(o_hi), 64'(exp_v[63:32]));
        check("lo", 64'(o_lo), 64'(exp_v[31:0]));
        check("div0", 64'(o_div0), 64'(ed));
        check("alu_sel_cycles", 64'(sel_cnt), ed ? 64'(0) : 64'(32));
        check("alu_ctrl", 64'(ctrl_bad), 64'(0));
        check("alu_idle_zero", 64'(idle_bad), 64'(0));
        check("stall_during_op", 64'(stall_bad), 64'(0));
        @(negedge i_clk);
        check("done_one_cycle", 64'(o_done), 64'(0));
        check("idle_after_done", 64'(o_stall), 64'(0));
        check("div0_sticky", 64'(o_div0), 64'(ed));
        prev_hi = eh; prev_lo = el;
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        i_reset = 1'b0; i_start = 1'b0; i_op = 2'b00; i_A = 32'h0; i_B = 32'h0;
        #12;
        check("rst_hi", 64'(o_hi), 64'(0));
        check("rst_lo", 64'(o_lo), 64'(0));
        check("rst_stall", 64'(o_stall), 64'(0));
        check("rst_done", 64'(o_done), 64'(0));
        check("rst_div0", 64'(o_div0), 64'(0));
        check("rst_alu", {o_alu_A, o_alu_B[27:0], o_alu_ctrl}, 64'(0));
        check("rst_alu_sel", 64'(o_alu_sel), 64'(0));
        @(negedge i_clk);
        i_reset = 1'b1;

        // directed steps
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
        run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0005, -1, -1);
        run_op(2'b00, 32'h8000_0000, 32'h8000_0000, -1, -1);
        run_op(2'b11, 32'd100,       32'd7,         -1, -1);
        run_op(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
        run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, -1, -1);
        run_op(2'b10, 32'h0000_0007, 32'hFFFF_FFFE, -1, -1);
        run_op(2'b10, 32'd5,         32'd0,         -1, -1);
        run_op(2'b00, 32'd6,         32'd7,         -1, -1);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
        run_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, 10, -1);
        run_op(2'b10, 32'hDEAD_BEEF, 32'h0000_0123, -1, 20);
        run_op(2'b11, 32'hCAFE_F00D, 32'h0000_0011, -1, -1);

        // random operations
        for (int n = 0; n < 24; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       rb = 32'h8000_0000;
                3:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb, -1, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
